uart_rx: RTL
============

# uart_rx

UART receiver for the AXI peripheral subsystem, the receive-side counterpart of the byte transmitter on the same serial link. It synchronises the asynchronous `rx` line, detects start bits, samples 8N1 frames at mid-bit, and presents each received byte in a one-entry holding register with a valid/read handshake. Framing errors and overruns are flagged to the bus-side register block.

## Interface
- `CLK_PER_BIT`, default 20: clk cycles per bit. Must equal the transmitter's setting. Legal range 4..65535, held in a 16-bit counter.
- `clk`  in  1  system clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `rx`  in  1  serial input, idle high, asynchronous to `clk`
- `rx_read`  in  1  one-cycle pulse from the consumer that pops the holding register
- `data_out`  out  8  received byte, LSB = first data bit
- `rx_valid`  out  1  level signal, high while `data_out` holds an unread byte
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low
- `overrun`  out  1  sticky flag, a good frame arrived while `rx_valid` was high; cleared by `rx_read`

## Operation
- Synchroniser: two flops on `rx`, both reset to 1. The second flop output is `rx_s`. All FSM decisions use `rx_s` only.
- Bit counter `bit_cnt` is 3 bits. Shift register is 8 bits. Sample counter `cnt` is 16 bits.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
  - **IDLE**:
    - `cnt` = 0 and `bit_cnt` = 0.
    - If `rx_s` = 0, go to START.
  - **START**:
    - `cnt` increments each cycle.
    - At `cnt` == CLK_PER_BIT/2 − 1 (integer division):
      - If `rx_s` = 0, go to DATA with `cnt` ← 0.
      - If `rx_s` = 1, treat it as a glitch and return to IDLE. No flag is raised.
  - **DATA**:
    - `cnt` counts 0..CLK_PER_BIT−1 and wraps.
    - At `cnt` == CLK_PER_BIT−1, `shreg[bit_cnt]` ← `rx_s` and `bit_cnt` increments.
    - When bit 7 is sampled, go to STOP with `cnt` ← 0.
  - **STOP**: at `cnt` == CLK_PER_BIT−1, sample `rx_s`.
    - If `rx_s` = 1 (good frame): go to IDLE.
      - If `rx_valid` = 0, or `rx_read` = 1 in the same cycle: load `data_out` ← `shreg` and set `rx_valid` ← 1.
      - Otherwise: drop the new byte, keep `data_out` unchanged, and set `overrun` ← 1.
    - If `rx_s` = 0: pulse `frame_err` for one cycle, discard the byte, go to WAIT_HIGH.
  - **WAIT_HIGH**: stay until `rx_s` = 1, then go to IDLE. This prevents a held-low line or break condition from being read as a new start bit.
- Handshake:
  - `rx_read` while `rx_valid` = 1 clears `rx_valid` and `overrun` on the next edge. `data_out` stays unchanged until the next load.
  - `rx_read` while `rx_valid` = 0 has no effect, apart from clearing `overrun`.
  - Load and `rx_read` in the same cycle: the load wins, so `rx_valid` stays 1 with the new byte and `overrun` is not set.
- Reset, asserted at any time including mid-frame:
  - `data_out` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - State = IDLE, all counters 0, synchroniser flops = 1.
  - After release, reception resumes at the next falling edge seen on `rx_s`.

## Timing
- `rx` to `rx_s` latency: 2 cycles.
- With CLK_PER_BIT = 20 and `rx` falling just before edge 0:
  - START is entered at edge 2; the start-bit check occurs at edge 12.
  - Data bit *n* is sampled at edge 32 + 20·n, about mid-bit after the synchroniser delay.
  - The stop bit is sampled at edge 192; `rx_valid` and `data_out` are valid after edge 192.
  - A `frame_err` pulse occurs in the cycle after edge 192.
- The FSM is back in IDLE half a bit before the stop bit ends, so back-to-back frames with zero idle time are received without loss.
- All outputs are registered. There is no combinational path from `rx` or `rx_read` to any output.

## Test plan
- Send 0xA5 (8N1, 20 cycles/bit) -> `rx_valid` rises 192±1 cycles after the start edge, `data_out` = 0xA5, `frame_err` and `overrun` stay 0. Then `rx_read` -> `rx_valid` = 0 the next cycle.
- Send 0x00 and 0xFF back-to-back with no idle gap, reading each byte -> two valid bytes in order, no errors.
- Drive `rx` low for 4 cycles only -> no `rx_valid` and no `frame_err`; FSM back in IDLE.
- Send 0x3C with the stop bit driven low, holding `rx` low for 3 bit times -> one `frame_err` pulse, `rx_valid` stays 0. The next good frame 0x81 is received correctly.
- Send 0x11, do not read, then send 0x22 -> `data_out` = 0x11, `overrun` = 1. Then `rx_read` -> `rx_valid` = 0, `overrun` = 0. Repeat with `rx_read` pulsed in the exact completion cycle of 0x22 -> `data_out` = 0x22, `rx_valid` = 1, `overrun` = 0.
- Assert `resetn` low during data bit 4 of a frame -> all outputs 0 immediately. After release, a fresh 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, start-bit qualification at half a bit,
// mid-bit data sampling, and a one-entry holding register with overrun/framing flags.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line idle, counters cleared, waiting for rx_s low
// START     | half-bit qualification of the start bit (glitch filter)
// DATA      | sampling 8 data bits, one every CLK_PER_BIT cycles
// STOP      | sampling the stop bit, load or flag the result
// WAIT_HIGH | after a framing error, wait for the line to return high
module uart_rx #(
  parameter int unsigned CLK_PER_BIT = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  input  logic       rx_read,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] HALF_M1 = 16'(CLK_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q;
  logic        rx_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  // Both stages reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;

    // A pop clears both flags; a load later in this block overrides valid.
    if (rx_read) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d              = '0;
          shreg_d[bit_cnt_q] = rx_s_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
            if (!valid_q || rx_read) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_WAIT_HIGH: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign data_out  = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
